// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 keyboard receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Bytes swallowed after an E1 prefix (rest of the Pause sequence).
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int KEY_TOGGLE = 10;
    localparam int KEY_PRESS  = 9;
    localparam int KEY_EXT    = 8;

    // Keyboard response / status codes that never describe a key.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_filter.sv
// ============================================================================
// Module      : ps2_line_filter
// Description : 2-FF synchroniser, counter deglitch filter and fall detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic fall
);

    logic [1:0] r_sync;
    logic [7:0] r_cnt;
    logic       r_level;
    logic       r_fall;
    logic       w_differ;
    logic       w_flip;

    assign w_differ = r_sync[1] ^ r_level;
    assign w_flip   = w_differ && (r_cnt == 8'(FILTER_LEN - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= 2'b11;
            r_cnt   <= 8'd0;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], raw};
            // Any sample agreeing with the current level restarts the count.
            if (!w_differ) begin
                r_cnt <= 8'd0;
            end else if (w_flip) begin
                r_cnt   <= 8'd0;
                r_level <= ~r_level;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
            r_fall <= w_flip & r_level;
        end
    end

    assign level = r_level;
    assign fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/ps2_key_rx.sv
// ============================================================================
// Module      : ps2_key_rx
// Description : PS/2 frame receiver and Set-2 scan-code decoder producing the
//               toggle-style ps2_key event word. Optional typematic-repeat
//               suppression when PS2_TYPEMATIC_FILTER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ   = 64000000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic [10:0] ps2_key,
    output logic        err
);

    localparam int TMO_CYCLES = CLK_FREQ / 1000000 * TIMEOUT_US;
    localparam int TMO_W      = $clog2(TMO_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    logic w_fall;
    logic w_data;
    logic w_clk_level_unused;
    logic w_data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (ps2_clk_i),
        .level   (w_clk_level_unused),
        .fall    (w_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (ps2_data_i),
        .level   (w_data),
        .fall    (w_data_fall_unused)
    );

    frame_state_t     r_state, w_state_nx;
    logic [2:0]       r_bitcnt, w_bitcnt_nx;
    logic [7:0]       r_shift, w_shift_nx;
    logic             r_parity, w_parity_nx;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_byte_ok;
    logic             w_frame_err;
    logic             w_timeout;

    always_comb begin
        w_state_nx  = r_state;
        w_bitcnt_nx = r_bitcnt;
        w_shift_nx  = r_shift;
        w_parity_nx = r_parity;
        w_byte_ok   = 1'b0;
        w_frame_err = 1'b0;
        w_timeout   = 1'b0;
        if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_data) begin
                        w_state_nx  = ST_DATA;
                        w_bitcnt_nx = 3'd0;
                    end
                end
                ST_DATA: begin
                    w_shift_nx  = {w_data, r_shift[7:1]};
                    w_bitcnt_nx = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) w_state_nx = ST_PARITY;
                end
                ST_PARITY: begin
                    w_parity_nx = w_data;
                    w_state_nx  = ST_STOP;
                end
                ST_STOP: begin
                    w_state_nx = ST_IDLE;
                    if (w_data && (^{r_shift, r_parity})) w_byte_ok = 1'b1;
                    else                                  w_frame_err = 1'b1;
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end else if ((r_state != ST_IDLE) && (r_tmo_cnt == TMO_LAST)) begin
            w_timeout  = 1'b1;
            w_state_nx = ST_IDLE;
        end
    end

    logic       r_byte_stb;
    logic [7:0] r_byte;
    logic       r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_bitcnt   <= 3'd0;
            r_shift    <= 8'd0;
            r_parity   <= 1'b0;
            r_tmo_cnt  <= '0;
            r_byte_stb <= 1'b0;
            r_byte     <= 8'd0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_bitcnt   <= w_bitcnt_nx;
            r_shift    <= w_shift_nx;
            r_parity   <= w_parity_nx;
            r_byte_stb <= w_byte_ok;
            r_err      <= w_frame_err | w_timeout;
            if (w_byte_ok) r_byte <= r_shift;
            if (w_fall || (r_state == ST_IDLE) || w_timeout) r_tmo_cnt <= '0;
            else                                             r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    logic        r_ext;
    logic        r_brk;
    logic [2:0]  r_skip;
    logic [10:0] r_key;
    logic        w_code;
    logic        w_suppress;

    assign w_code = r_byte_stb && (r_skip == 3'd0) && (r_byte != PS2_PAUSE) &&
                    (r_byte != PS2_EXT) && (r_byte != PS2_BRK) && !is_discard(r_byte);

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] r_last_make;
    logic       r_last_valid;

    assign w_suppress = !r_brk && r_last_valid && (r_last_make == {r_ext, r_byte});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_make  <= 9'd0;
            r_last_valid <= 1'b0;
        end else if (w_code) begin
            if (!r_brk) begin
                r_last_make  <= {r_ext, r_byte};
                r_last_valid <= 1'b1;
            end else if (r_last_make == {r_ext, r_byte}) begin
                r_last_valid <= 1'b0;
            end
        end
    end
`else
    assign w_suppress = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_skip <= 3'd0;
            r_key  <= 11'd0;
        end else if (r_byte_stb) begin
            if (r_skip != 3'd0) begin
                r_skip <= r_skip - 3'd1;
            end else if (r_byte == PS2_PAUSE) begin
                r_skip <= PAUSE_SKIP;
            end else if (r_byte == PS2_EXT) begin
                r_ext <= 1'b1;
            end else if (r_byte == PS2_BRK) begin
                r_brk <= 1'b1;
            end else if (w_code) begin
                if (!w_suppress) r_key <= {~r_key[KEY_TOGGLE], ~r_brk, r_ext, r_byte};
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    assign ps2_key = r_key;
    assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_rx.sv
// ============================================================================
// Module      : tb_ps2_key_rx
// Description : Self-checking bench for ps2_key_rx with a behavioural decoder
//               model; honours PS2_TYPEMATIC_FILTER_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_key_rx;

    localparam int CLK_FREQ   = 2000000;
    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT_US = 100;
    localparam int TMO_CYCLES = CLK_FREQ / 1000000 * TIMEOUT_US;
    localparam int HALF       = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk_i = 1'b1;
    logic        ps2_data_i = 1'b1;
    logic [10:0] ps2_key;
    logic        err;

    ps2_key_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_US (TIMEOUT_US)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .ps2_key    (ps2_key),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Independent observers of the outputs.
    int   err_pulses = 0;
    int   err_cycles = 0;
    int   toggles = 0;
    logic err_q = 1'b0;
    logic tog_q = 1'b0;
    always @(posedge clk) begin
        err_q <= err;
        tog_q <= ps2_key[10];
        if (err) err_cycles <= err_cycles + 1;
        if (err && !err_q) err_pulses <= err_pulses + 1;
        if (reset_n && (ps2_key[10] != tog_q)) toggles <= toggles + 1;
    end

    // Behavioural decoder model.
    logic [10:0] m_key;
    logic        m_ext, m_brk;
    int          m_skip;
    int          m_err;
    logic [8:0]  m_last;
    logic        m_last_valid;

    task automatic m_reset();
        m_key = 11'd0; m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
        m_last = 9'd0; m_last_valid = 1'b0;
    endtask

    task automatic m_apply(input logic [7:0] b);
        logic emit;
        if (m_skip > 0) begin
            m_skip = m_skip - 1;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
            emit = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (!m_brk) begin
                if (m_last_valid && m_last == {m_ext, b}) emit = 1'b0;
                else begin m_last = {m_ext, b}; m_last_valid = 1'b1; end
            end else if (m_last == {m_ext, b}) begin
                m_last_valid = 1'b0;
            end
`endif
            if (emit) m_key = {~m_key[10], ~m_brk, m_ext, b};
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives nbits of a frame (start, 8 data, parity, stop); glitch_bit >= 0
    // injects a FILTER_LEN-1 cycle low pulse in that bit's high phase.
    task automatic drive_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int glitch_bit, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data_i = f[i];
            if (i == glitch_bit) begin
                cyc(4);
                ps2_clk_i = 1'b0;
                cyc(FILTER_LEN - 1);
                ps2_clk_i = 1'b1;
                cyc(HALF - 4 - (FILTER_LEN - 1));
            end else begin
                cyc(HALF);
            end
            ps2_clk_i = 1'b0;
            cyc(HALF);
            ps2_clk_i = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int glitch_bit);
        drive_bits(b, bad_par, bad_stop, glitch_bit, 11);
        ps2_data_i = 1'b1;
        cyc(HALF + 20);
        if (bad_par || bad_stop) m_err = m_err + 1;
        else                     m_apply(b);
    endtask

    task automatic check_model(input string name);
        checks++;
        if (ps2_key !== m_key) begin
            failures++;
            $display("FAIL %s key: got %h expected %h", name, ps2_key, m_key);
        end
        checks++;
        if (err_pulses !== m_err || err_cycles !== m_err) begin
            failures++;
            $display("FAIL %s err: pulses %0d cycles %0d expected %0d", name, err_pulses, err_cycles, m_err);
        end
    endtask

    task automatic test_reset();
        m_reset();
        m_err = 0;
        cyc(5);
        checks++;
        if (ps2_key !== 11'h000 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: key %h err %b expected 000 0", ps2_key, err);
        end
        reset_n = 1'b1;
        cyc(5);
        drive_bits(8'h1C, 1'b0, 1'b0, -1, 5);
        reset_n = 1'b0;
        ps2_clk_i = 1'b1;
        ps2_data_i = 1'b1;
        cyc(3);
        reset_n = 1'b1;
        cyc(60);
        checks++;
        if (ps2_key !== 11'h000 || err_pulses !== 0) begin
            failures++;
            $display("FAIL midframe_reset: key %h errs %0d expected 000 0", ps2_key, err_pulses);
        end
    endtask

    task automatic test_single();
        send(8'h1C, 0, 0, -1);
        checks++;
        if (ps2_key !== 11'h61C) begin
            failures++;
            $display("FAIL single_1C: got %h expected 61C", ps2_key);
        end
        check_model("single");
    endtask

    task automatic test_prefix();
        int t0;
        t0 = toggles;
        send(8'hE0, 0, 0, -1);
        send(8'hF0, 0, 0, -1);
        send(8'h75, 0, 0, -1);
        checks++;
        if (ps2_key[9:0] !== 10'h175 || toggles - t0 !== 1) begin
            failures++;
            $display("FAIL prefix_E0F075: key %h toggles %0d expected x175 1", ps2_key, toggles - t0);
        end
        send(8'h1C, 0, 0, -1);
        checks++;
        if (ps2_key[9:0] !== 10'h21C) begin
            failures++;
            $display("FAIL prefix_cleared: got %h expected x21C", ps2_key[9:0]);
        end
        check_model("prefix");
    endtask

    task automatic test_parity_error();
        logic [10:0] k;
        k = ps2_key;
        send(8'h29, 1, 0, -1);
        checks++;
        if (ps2_key !== k) begin
            failures++;
            $display("FAIL parity_err_key: got %h expected %h", ps2_key, k);
        end
        check_model("parity_err");
        send(8'h5A, 0, 1, -1);
        check_model("stop_err");
        send(8'h29, 0, 0, -1);
        checks++;
        if (ps2_key !== {~k[10], 10'h229}) begin
            failures++;
            $display("FAIL parity_recover: got %h expected %h", ps2_key, {~k[10], 10'h229});
        end
    endtask

    task automatic test_timeout();
        drive_bits(8'h33, 0, 0, -1, 5);
        ps2_data_i = 1'b1;
        cyc(TMO_CYCLES + 100);
        m_err = m_err + 1;
        check_model("timeout");
        send(8'h5A, 0, 0, -1);
        checks++;
        if (ps2_key[9:0] !== 10'h25A) begin
            failures++;
            $display("FAIL timeout_recover: got %h expected x25A", ps2_key[9:0]);
        end
        check_model("timeout_recover");
    endtask

    task automatic test_glitch_pause();
        logic [7:0] seq [8];
        int t0;
        send(8'h4B, 0, 0, 3);
        check_model("glitch");
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        t0 = toggles;
        for (int i = 0; i < 8; i++) send(seq[i], 0, 0, -1);
        checks++;
        if (toggles !== t0) begin
            failures++;
            $display("FAIL pause_seq: toggles %0d expected 0", toggles - t0);
        end
        check_model("pause");
    endtask

    task automatic test_typematic();
        logic [7:0] seq [5];
        int t0;
        int exp_t;
`ifdef PS2_TYPEMATIC_FILTER_EN
        exp_t = 3;
`else
        exp_t = 4;
`endif
        seq = '{8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        send(8'h2B, 0, 0, -1);
        t0 = toggles;
        for (int i = 0; i < 5; i++) send(seq[i], 0, 0, -1);
        checks++;
        if (toggles - t0 !== exp_t) begin
            failures++;
            $display("FAIL typematic: toggles %0d expected %0d", toggles - t0, exp_t);
        end
        check_model("typematic");
    endtask

    task automatic test_random();
        logic [7:0] pool [12];
        logic [7:0] b;
        bit bad;
        pool = '{8'h1C, 8'h29, 8'h5A, 8'h75, 8'h14, 8'h77, 8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA, 8'h00};
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) b = 8'($urandom);
            else                           b = pool[$urandom_range(0, 11)];
            bad = ($urandom_range(0, 9) == 0);
            send(b, bad, 0, -1);
            check_model("random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_parity_error();
        test_timeout();
        test_glitch_pause();
        test_typematic();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
